// File: rtl/control_unit.sv
// Moore-style instruction sequencer for the 8-bit CPU. Outputs are registered from the next state.
// Optional feature macro CU_ILLEGAL_TRAP_EN: an undefined opcode parks the sequencer in HALT until reset.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic [2:0] ALU_Sel,
    output logic       CCR_Load,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       write
);

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_BRA     = 8'h20;

    localparam logic [1:0] BUS1_PC  = 2'b00;
    localparam logic [1:0] BUS1_A   = 2'b01;
    localparam logic [1:0] BUS1_B   = 2'b10;
    localparam logic [1:0] BUS2_ALU = 2'b00;
    localparam logic [1:0] BUS2_B1  = 2'b01;
    localparam logic [1:0] BUS2_MEM = 2'b10;

    typedef enum logic [4:0] {
        FETCH_0,
        FETCH_1,
        FETCH_2,
        DECODE_3,
        OPF_4,
        OPF_5,
        LD_6,
        DIR_6,
        DIR_7,
        DIR_8,
        ST_7,
        ALU_4,
        BR_4,
        BR_5,
        BR_6,
        BNT_4,
        HALT
    } state_t;

    typedef struct packed {
        logic       ir_load;
        logic       mar_load;
        logic       pc_load;
        logic       pc_inc;
        logic       a_load;
        logic       b_load;
        logic [2:0] alu_sel;
        logic       ccr_load;
        logic [1:0] bus1_sel;
        logic [1:0] bus2_sel;
        logic       write;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl_q;

    function automatic logic is_ld_imm(input logic [7:0] op);
        return (op == OP_LDA_IMM) || (op == OP_LDB_IMM);
    endfunction

    function automatic logic is_ld_dir(input logic [7:0] op);
        return (op == OP_LDA_DIR) || (op == OP_LDB_DIR);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OP_STA_DIR) || (op == OP_STB_DIR);
    endfunction

    function automatic logic is_branch(input logic [7:0] op);
        return (op >= OP_BRA) && (op <= 8'h28);
    endfunction

    function automatic logic is_alu(input logic [7:0] op);
        return op inside {8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h48, 8'h4A, 8'h4B};
    endfunction

    // Flags are {N,Z,V,C}; odd opcodes test a flag set, even ones test it clear.
    function automatic logic branch_taken(input logic [7:0] op, input logic [3:0] ccr);
        logic taken;
        taken = 1'b0;
        case (op)
            8'h20:   taken = 1'b1;
            8'h21:   taken = ccr[3];
            8'h22:   taken = ~ccr[3];
            8'h23:   taken = ccr[2];
            8'h24:   taken = ~ccr[2];
            8'h25:   taken = ccr[1];
            8'h26:   taken = ~ccr[1];
            8'h27:   taken = ccr[0];
            8'h28:   taken = ~ccr[0];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic [2:0] alu_code(input logic [7:0] op);
        logic [2:0] code;
        code = 3'b000;
        case (op)
            8'h42:   code = 3'b000;
            8'h43:   code = 3'b001;
            8'h44:   code = 3'b010;
            8'h45:   code = 3'b011;
            8'h46:   code = 3'b100;
            8'h48:   code = 3'b101;
            8'h4A:   code = 3'b110;
            8'h4B:   code = 3'b111;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    function automatic state_t dispatch(input logic [7:0] op, input logic [3:0] ccr);
        state_t s;
        if (is_ld_imm(op) || is_ld_dir(op) || is_store(op)) begin
            s = OPF_4;
        end else if (is_alu(op)) begin
            s = ALU_4;
        end else if (is_branch(op)) begin
            s = branch_taken(op, ccr) ? BR_4 : BNT_4;
        end else begin
`ifdef CU_ILLEGAL_TRAP_EN
            s = HALT;
`else
            s = FETCH_0;
`endif
        end
        return s;
    endfunction

    // IR is only reloaded in FETCH_2, so it stays valid for every later state of the instruction.
    function automatic state_t next_state(input state_t s, input logic [7:0] op,
                                          input logic [3:0] ccr);
        state_t n;
        n = FETCH_0;
        case (s)
            FETCH_0:  n = FETCH_1;
            FETCH_1:  n = FETCH_2;
            FETCH_2:  n = DECODE_3;
            DECODE_3: n = dispatch(op, ccr);
            OPF_4:    n = OPF_5;
            OPF_5:    n = is_ld_imm(op) ? LD_6 : DIR_6;
            DIR_6:    n = is_store(op) ? ST_7 : DIR_7;
            DIR_7:    n = DIR_8;
            BR_4:     n = BR_5;
            BR_5:     n = BR_6;
            HALT:     n = HALT;
            default:  n = FETCH_0;
        endcase
        return n;
    endfunction

    function automatic ctrl_t controls_for(input state_t s, input logic [7:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH_0, OPF_4, BR_4: begin
                c.bus1_sel = BUS1_PC;
                c.bus2_sel = BUS2_B1;
                c.mar_load = 1'b1;
            end
            FETCH_1, OPF_5, BNT_4: c.pc_inc = 1'b1;
            FETCH_2: begin
                c.bus2_sel = BUS2_MEM;
                c.ir_load  = 1'b1;
            end
            LD_6, DIR_8: begin
                c.bus2_sel = BUS2_MEM;
                c.a_load   = (op == OP_LDA_IMM) || (op == OP_LDA_DIR);
                c.b_load   = (op == OP_LDB_IMM) || (op == OP_LDB_DIR);
            end
            DIR_6: begin
                c.bus2_sel = BUS2_MEM;
                c.mar_load = 1'b1;
            end
            ST_7: begin
                c.bus1_sel = (op == OP_STA_DIR) ? BUS1_A : BUS1_B;
                c.write    = 1'b1;
            end
            ALU_4: begin
                c.bus2_sel = BUS2_ALU;
                c.a_load   = 1'b1;
                c.ccr_load = 1'b1;
                c.alu_sel  = alu_code(op);
            end
            BR_6: begin
                c.bus2_sel = BUS2_MEM;
                c.pc_load  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign state_nxt = next_state(state, IR, CCR_Result);

    // Output register is loaded with the decode of the state being entered, keeping outputs glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH_0;
            ctrl_q <= controls_for(FETCH_0, IR);
        end else begin
            state  <= state_nxt;
            ctrl_q <= controls_for(state_nxt, IR);
        end
    end

    // Reset masks the registered outputs at once so an aborted instruction never pulses a load or write.
    assign IR_Load  = ctrl_q.ir_load  & ~reset;
    assign MAR_Load = ctrl_q.mar_load & ~reset;
    assign PC_Load  = ctrl_q.pc_load  & ~reset;
    assign PC_Inc   = ctrl_q.pc_inc   & ~reset;
    assign A_Load   = ctrl_q.a_load   & ~reset;
    assign B_Load   = ctrl_q.b_load   & ~reset;
    assign ALU_Sel  = reset ? 3'b000 : ctrl_q.alu_sel;
    assign CCR_Load = ctrl_q.ccr_load & ~reset;
    assign Bus1_Sel = reset ? 2'b00 : ctrl_q.bus1_sel;
    assign Bus2_Sel = reset ? 2'b00 : ctrl_q.bus2_sel;
    assign write    = ctrl_q.write    & ~reset;

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit: a per-instruction model predicts every cycle's outputs.
// Honours CU_ILLEGAL_TRAP_EN the same way the design does.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;

    int checks = 0;
    int errors = 0;

    logic [14:0] expQ[$];
    logic [7:0]  aluOps[8] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h48, 8'h4A, 8'h4B};
    logic [7:0]  legalOps[25] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97,
                                  8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h48, 8'h4A, 8'h4B,
                                  8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
                                  8'h86, 8'h97};

    control_unit dut (
        .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
        .A_Load(A_Load), .B_Load(B_Load), .ALU_Sel(ALU_Sel), .CCR_Load(CCR_Load),
        .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] observed();
        return {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel, CCR_Load,
                Bus1_Sel, Bus2_Sel, write};
    endfunction

    // Named-field constructor so expected words read like the control table.
    function automatic logic [14:0] mk(input logic irl, input logic mar, input logic pcl,
                                       input logic pci, input logic al, input logic bl,
                                       input logic [2:0] alu, input logic ccr,
                                       input logic [1:0] b1, input logic [1:0] b2,
                                       input logic wr);
        return {irl, mar, pcl, pci, al, bl, alu, ccr, b1, b2, wr};
    endfunction

    function automatic logic isLegal(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        foreach (legalOps[k]) if (legalOps[k] == op) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic takenModel(input logic [7:0] op, input logic [3:0] ccr);
        logic flag;
        if (op == 8'h20) return 1'b1;
        // 21/22 test N, 23/24 Z, 25/26 V, 27/28 C; odd opcode means "flag set".
        flag = ccr[3 - int'((op - 8'h21) >> 1)];
        return op[0] ? flag : ~flag;
    endfunction

    task automatic checkOutput(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic buildExpected(input logic [7:0] op, input logic [3:0] ccr);
        logic [14:0] marFromPc;
        marFromPc = mk(0, 1, 0, 0, 0, 0, 3'd0, 0, 2'b00, 2'b01, 0);
        expQ.delete();
        expQ.push_back(marFromPc);
        expQ.push_back(mk(0, 0, 0, 1, 0, 0, 3'd0, 0, 2'b00, 2'b00, 0));
        expQ.push_back(mk(1, 0, 0, 0, 0, 0, 3'd0, 0, 2'b00, 2'b10, 0));
        expQ.push_back('0);
        if (op == 8'h86 || op == 8'h88 || op == 8'h87 || op == 8'h89 ||
            op == 8'h96 || op == 8'h97) begin
            expQ.push_back(marFromPc);
            expQ.push_back(mk(0, 0, 0, 1, 0, 0, 3'd0, 0, 2'b00, 2'b00, 0));
            if (op == 8'h86 || op == 8'h88) begin
                expQ.push_back(mk(0, 0, 0, 0, op == 8'h86, op == 8'h88, 3'd0, 0, 2'b00, 2'b10, 0));
            end else begin
                expQ.push_back(mk(0, 1, 0, 0, 0, 0, 3'd0, 0, 2'b00, 2'b10, 0));
                if (op == 8'h96 || op == 8'h97) begin
                    expQ.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0,
                                      (op == 8'h96) ? 2'b01 : 2'b10, 2'b00, 1));
                end else begin
                    expQ.push_back('0);
                    expQ.push_back(mk(0, 0, 0, 0, op == 8'h87, op == 8'h89, 3'd0, 0,
                                      2'b00, 2'b10, 0));
                end
            end
        end
        foreach (aluOps[k]) begin
            if (aluOps[k] == op)
                expQ.push_back(mk(0, 0, 0, 0, 1, 0, 3'(k), 1, 2'b00, 2'b00, 0));
        end
        if (op >= 8'h20 && op <= 8'h28) begin
            if (takenModel(op, ccr)) begin
                expQ.push_back(marFromPc);
                expQ.push_back('0);
                expQ.push_back(mk(0, 0, 1, 0, 0, 0, 3'd0, 0, 2'b00, 2'b10, 0));
            end else begin
                expQ.push_back(mk(0, 0, 0, 1, 0, 0, 3'd0, 0, 2'b00, 2'b00, 0));
            end
        end
    endtask

    // Called just after a posedge; reset is high for exactly one cycle and must blank every output.
    task automatic doReset(input string tag);
        reset = 1'b1;
        @(negedge clk);
        checkOutput(tag, observed(), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Runs one instruction starting in FETCH_0; the next instruction's first word proves the return to FETCH_0.
    task automatic applyStimulus(input logic [7:0] op, input logic [3:0] ccr);
        IR = op;
        CCR_Result = ccr;
        buildExpected(op, ccr);
        for (int i = 0; i < expQ.size(); i++) begin
            @(negedge clk);
            checkOutput($sformatf("op%02h ccr%h cyc%0d", op, ccr, i), observed(), expQ[i]);
            @(posedge clk);
            #1;
        end
`ifdef CU_ILLEGAL_TRAP_EN
        if (!isLegal(op)) begin
            for (int i = 0; i < 22; i++) begin
                @(negedge clk);
                checkOutput($sformatf("halt op%02h cyc%0d", op, i), observed(), '0);
                @(posedge clk);
                #1;
            end
            doReset("haltReset");
        end
`endif
    endtask

    // Runs the first n cycles of an instruction and then resets in the middle of it.
    task automatic midReset(input logic [7:0] op, input logic [3:0] ccr, input int n);
        IR = op;
        CCR_Result = ccr;
        buildExpected(op, ccr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput($sformatf("pre op%02h cyc%0d", op, i), observed(), expQ[i]);
            @(posedge clk);
            #1;
        end
        doReset($sformatf("midReset op%02h cyc%0d", op, n));
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] op;
        logic [3:0] ccr;
        reset = 1'b1;
        IR = 8'h00;
        CCR_Result = 4'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        IR = 8'h86;
        @(negedge clk);
        checkOutput("resetState", observed(), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(8'h86, 4'h0);
        applyStimulus(8'h96, 4'h0);
        applyStimulus(8'h43, 4'h0);
        applyStimulus(8'h23, 4'b0100);
        applyStimulus(8'h23, 4'b0000);
        applyStimulus(8'hFF, 4'h0);
        midReset(8'h89, 4'h0, 7);
        midReset(8'h89, 4'h0, 8);
        midReset(8'h97, 4'h0, 7);
        applyStimulus(8'h87, 4'hF);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 255));
            else op = legalOps[$urandom_range(0, 24)];
            ccr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0 && isLegal(op)) begin
                buildExpected(op, ccr);
                midReset(op, ccr, $urandom_range(0, expQ.size() - 1));
            end else begin
                applyStimulus(op, ccr);
            end
        end
        applyStimulus(8'h42, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; opcode values are fixed by this document.
REQ-002 The block SHALL use a single clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  sole clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- IR  in  8  current instruction register contents.
- CCR_Result  in  4  condition flags {N,Z,V,C}, with N at bit 3.
- IR_Load  out  1  load IR from Bus2.
- MAR_Load  out  1  load MAR from Bus2.
- PC_Load  out  1  load PC from Bus2.
- PC_Inc  out  1  increment PC.
- A_Load  out  1  load register A from Bus2.
- B_Load  out  1  load register B from Bus2.
- ALU_Sel  out  3  ALU operation code.
- CCR_Load  out  1  capture ALU flags.
- Bus1_Sel  out  2  Bus1 source: 00=PC, 01=A, 10=B.
- Bus2_Sel  out  2  Bus2 source: 00=ALU, 01=Bus1, 10=memory data_out.
- write  out  1  memory write strobe.

Function
REQ-003 The block SHALL be a Moore FSM; every output SHALL be 0 in a state unless listed for that state.
REQ-004 The memory is synchronous with 1-cycle read latency, so data SHALL be sampled from Bus2=10 no earlier than 2 states after the MAR_Load.
REQ-005 The fetch sequence SHALL be:
- FETCH_0: Bus1=00, Bus2=01, MAR_Load.
- FETCH_1: PC_Inc.
- FETCH_2: Bus2=10, IR_Load.
- DECODE_3: no outputs; dispatch on IR.
REQ-006 The operand fetch (OPF) sequence SHALL be:
- OPF_4: Bus1=00, Bus2=01, MAR_Load.
- OPF_5: PC_Inc.
REQ-007 LDA_IMM 86h / LDB_IMM 88h SHALL run OPF_4, OPF_5, then LD_6 (Bus2=10, A_Load or B_Load), then FETCH_0.
REQ-008 LDA_DIR 87h / LDB_DIR 89h SHALL run OPF_4, OPF_5, then:
- DIR_6: Bus2=10, MAR_Load.
- DIR_7: wait.
- DIR_8: Bus2=10, A_Load or B_Load.
REQ-009 STA_DIR 96h / STB_DIR 97h SHALL run OPF_4, OPF_5, DIR_6, then ST_7 (Bus1=01 for A or 10 for B, write).
REQ-010 ALU ops SHALL complete in a single state ALU_4 (Bus2=00, A_Load, CCR_Load, ALU_Sel), with ALU_Sel encoded as:
- 42h→000 (ADD), 43h→001 (SUB), 44h→010 (AND), 45h→011 (OR).
- 46h→100 (INCA), 48h→101 (DECA), 4Ah→110 (XOR), 4Bh→111 (NOTA).
REQ-011 A taken branch SHALL run:
- BR_4: Bus1=00, Bus2=01, MAR_Load.
- BR_5: wait.
- BR_6: Bus2=10, PC_Load.
REQ-012 BRA 20h SHALL always be taken.
REQ-013 Conditional branches SHALL be taken as follows: 21h N=1, 22h N=0, 23h Z=1, 24h Z=0, 25h V=1, 26h V=0, 27h C=1, 28h C=0.
REQ-014 The branch condition SHALL be evaluated from CCR_Result in DECODE_3.
REQ-015 A not-taken branch SHALL execute BNT_4 (PC_Inc, skipping the operand byte) and then return to FETCH_0.
REQ-016 Every instruction's final state SHALL transition to FETCH_0.
REQ-017 Cycle counts from FETCH_0 back to FETCH_0 SHALL be:
- ALU: 5.
- LD_IMM: 7.
- LD_DIR: 9.
- ST_DIR: 8.
- Branch taken: 7.
- Branch not taken: 5.
REQ-018 Undefined opcodes SHALL be handled per REQ-022/REQ-023.

Reset
REQ-019 While reset=1 at a posedge, the state SHALL become FETCH_0.
REQ-020 While reset=1, all outputs SHALL be forced to 0 regardless of state.
REQ-021 A reset asserted mid-instruction SHALL abort it with no write or load pulse issued in the reset cycle, and fetch SHALL restart in FETCH_0 on the first cycle after deassertion.

Configuration
REQ-022 With CU_ILLEGAL_TRAP_EN defined:
- An undefined opcode in DECODE_3 SHALL enter HALT.
- HALT SHALL hold all outputs at 0.
- HALT SHALL be exited only by reset.
REQ-023 Without CU_ILLEGAL_TRAP_EN, an undefined opcode SHALL behave as a 4-cycle NOP (DECODE_3 → FETCH_0), with no loads or writes.

Verification
REQ-024 Reset, then IR=86h: the sequence FETCH_0..FETCH_2, DECODE_3, OPF_4, OPF_5, LD_6 is observed, A_Load is high only in LD_6 with Bus2=10, and FETCH_0 recurs at cycle 8.
REQ-025 IR=96h: write=1 for exactly one cycle with Bus1=01; MAR_Load pulses twice, in OPF_4 and DIR_6.
REQ-026 IR=43h: ALU_Sel=001, A_Load=1 and CCR_Load=1 together for one cycle, then FETCH_0.
REQ-027 Branch conditions:
- IR=23h with CCR_Result=0100 → PC_Load asserted in BR_6.
- IR=23h with CCR_Result=0000 → PC_Inc asserted in BNT_4, PC_Load never asserted.
REQ-028 IR=FFh: with the macro, HALT holds outputs at 0 for 20+ cycles until reset; without it, FETCH_0 follows DECODE_3.
REQ-029 Reset asserted during DIR_7 of 89h: B_Load never asserted, and FETCH_0 occurs on the cycle after deassertion.
